// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences PLL reset, waits for the PLL to report lock, qualifies the lock
// over a stable window, holds the core in reset for a further margin, and
// then releases the core. Any loss of lock drops the core back into reset.
// Optional build macro: PLL_SUP_LOSS_COUNT_EN enables the saturating
// lock-loss counter; without it loss_count is tied to zero.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 1024,
   parameter int HOLD_CYCLES    = 256,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int PLL_RST_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked_in,
   output logic       pll_rst,
   output logic       core_reset,
   output logic       ready,
   output logic       lost_pulse,
   output logic [7:0] loss_count
);

   // One shared counter serves every timed state, so it must span the largest limit.
   localparam int MAX_AB  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CD  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
   localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_HOLD,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   locked_s;
   state_t                 state_reg;
   state_t                 state_next;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   lost_next;

   // Synchronizer chain for the asynchronous lock flag; only the last stage is trusted.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked_in};
      end
   end

   assign locked_s = sync_reg[SYNC_STAGES-1];

   // Next-state decision; a loss of lock is only reported when leaving RUN.
   always_comb begin
      state_next = state_reg;
      lost_next  = 1'b0;
      case (state_reg)
         ST_PLL_RST: begin
            if (cnt_reg == PLL_RST_LAST) begin
               state_next = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_next = ST_STABLE;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               state_next = ST_PLL_RST;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_next = ST_WAIT_LOCK;
            end else if (cnt_reg == STABLE_LAST) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!locked_s) begin
               state_next = ST_WAIT_LOCK;
            end else if (cnt_reg == HOLD_LAST) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_next = ST_WAIT_LOCK;
               lost_next  = 1'b1;
            end
         end
         default: begin
            state_next = ST_PLL_RST;
         end
      endcase
   end

   // State, shared counter and outputs decoded from the next state so they move together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_PLL_RST;
         cnt_reg    <= '0;
         pll_rst    <= 1'b1;
         core_reset <= 1'b1;
         ready      <= 1'b0;
         lost_pulse <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_next != state_reg) begin
            cnt_reg <= '0;
         end else if (state_reg != ST_RUN) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
         pll_rst    <= (state_next == ST_PLL_RST);
         core_reset <= (state_next != ST_RUN);
         ready      <= (state_next == ST_RUN);
         lost_pulse <= lost_next;
      end
   end

`ifdef PLL_SUP_LOSS_COUNT_EN
   logic [7:0] loss_cnt_reg;

   // Saturating count of lock losses seen from RUN; cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         loss_cnt_reg <= 8'd0;
      end else if (lost_next && (loss_cnt_reg != 8'hFF)) begin
         loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
   end

   assign loss_count = loss_cnt_reg;
`else
   assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
// Directed scenarios plus randomized lock/unlock patterns, every cycle
// compared against a phase/age reference model. Works with or without
// PLL_SUP_LOSS_COUNT_EN defined.
module tb_pll_lock_supervisor;

   localparam int SYNC    = 2;
   localparam int STABLE  = 8;
   localparam int HOLD    = 4;
   localparam int TIMEOUT = 32;
   localparam int PRST    = 16;

   localparam int PH_PLLRST = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_HOLD   = 3;
   localparam int PH_RUN    = 4;

   logic       clk;
   logic       reset;
   logic       locked_in;
   logic       pll_rst;
   logic       core_reset;
   logic       ready;
   logic       lost_pulse;
   logic [7:0] loss_count;

   int    n_checks;
   int    n_pass;
   string phase_tag;

   // reference model state
   int   m_ph;
   int   m_age;
   int   m_lcnt;
   logic m_lost;
   logic sq[$];
   int   dur[5];

   pll_lock_supervisor #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .HOLD_CYCLES   (HOLD),
      .LOCK_TIMEOUT  (TIMEOUT),
      .PLL_RST_CYCLES(PRST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .locked_in (locked_in),
      .pll_rst   (pll_rst),
      .core_reset(core_reset),
      .ready     (ready),
      .lost_pulse(lost_pulse),
      .loss_count(loss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // One clock edge of the behavioural model: each phase has a fixed length,
   // lock loss (seen SYNC edges late) sends qualification back to waiting.
   task automatic model_edge(input logic li, input logic rst);
      logic ls;
      int   nph;
      if (rst) begin
         sq = {};
         for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
         m_ph   = PH_PLLRST;
         m_age  = 0;
         m_lost = 1'b0;
         m_lcnt = 0;
      end else begin
         ls = sq[SYNC-1];
         sq.push_front(li);
         void'(sq.pop_back());
         m_lost = 1'b0;
         nph    = m_ph;
         m_age  = m_age + 1;
         if (m_ph == PH_PLLRST) begin
            if (m_age == dur[PH_PLLRST]) nph = PH_WAIT;
         end else if (m_ph == PH_WAIT) begin
            if (ls) nph = PH_STABLE;
            else if (m_age == dur[PH_WAIT]) nph = PH_PLLRST;
         end else if (m_ph == PH_STABLE || m_ph == PH_HOLD) begin
            if (!ls) nph = PH_WAIT;
            else if (m_age == dur[m_ph]) nph = m_ph + 1;
         end else begin
            if (!ls) begin
               nph    = PH_WAIT;
               m_lost = 1'b1;
`ifdef PLL_SUP_LOSS_COUNT_EN
               if (m_lcnt < 255) m_lcnt = m_lcnt + 1;
`endif
            end
         end
         if (nph != m_ph) begin
            m_ph  = nph;
            m_age = 0;
         end
      end
   endtask

   task automatic compare_all();
      check({phase_tag, ".pll_rst"},    32'(pll_rst),    32'(m_ph == PH_PLLRST));
      check({phase_tag, ".core_reset"}, 32'(core_reset), 32'(m_ph != PH_RUN));
      check({phase_tag, ".ready"},      32'(ready),      32'(m_ph == PH_RUN));
      check({phase_tag, ".lost_pulse"}, 32'(lost_pulse), 32'(m_lost));
      check({phase_tag, ".loss_count"}, 32'(loss_count), 32'(m_lcnt));
   endtask

   task automatic step(input logic li, input logic rst);
      locked_in = li;
      reset     = rst;
      @(posedge clk);
      model_edge(li, rst);
      #1;
      compare_all();
   endtask

   initial begin
      int n_pll;
      int n;
      logic got;
      int len;
      int mode;
      int exp_sat;

      n_checks = 0;
      n_pass   = 0;
      dur[PH_PLLRST] = PRST;
      dur[PH_WAIT]   = TIMEOUT;
      dur[PH_STABLE] = STABLE;
      dur[PH_HOLD]   = HOLD;
      dur[PH_RUN]    = 0;
      locked_in = 1'b0;
      reset     = 1'b1;

      // reset state, then lock from cycle 20 with latency measurement
      phase_tag = "reset";
      repeat (3) step(1'b0, 1'b1);
      phase_tag = "lat";
      n_pll = 0;
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 1'b0);
         if (pll_rst === 1'b1) n_pll++;
      end
      check("lat.pll_rst_len", 32'(n_pll), 32'd15);
      n   = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         step(1'b1, 1'b0);
         n++;
         if (ready === 1'b1) got = 1'b1;
      end
      check("lat.ready_edges", 32'(n), 32'd15);
      check("lat.core_reset", 32'(core_reset), 32'd0);
      repeat (5) step(1'b1, 1'b0);

      // lock loss from RUN
      phase_tag = "loss";
      repeat (3) step(1'b0, 1'b0);
      check("loss.lost_pulse_edge3", 32'(lost_pulse), 32'd1);
      step(1'b0, 1'b0);
      check("loss.lost_pulse_once", 32'(lost_pulse), 32'd0);

      // glitch during STABLE at count 5 restarts qualification
      phase_tag = "stable_glitch";
      repeat (6) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      repeat (25) step(1'b1, 1'b0);
      check("stable_glitch.ready", 32'(ready), 32'd1);

      // lock never arrives: PLL reset retries
      phase_tag = "timeout";
      repeat (130) step(1'b0, 1'b0);
      check("timeout.ready", 32'(ready), 32'd0);

      // reset asserted while in RUN
      phase_tag = "run_reset";
      repeat (40) step(1'b1, 1'b0);
      check("run_reset.pre_ready", 32'(ready), 32'd1);
      step(1'b1, 1'b1);
      check("run_reset.pll_rst", 32'(pll_rst), 32'd1);
      check("run_reset.lost_pulse", 32'(lost_pulse), 32'd0);
      check("run_reset.loss_count", 32'(loss_count), 32'd0);

      // randomized lock patterns with occasional resets
      phase_tag = "rand";
      for (int s = 0; s < 600; s++) begin
         mode = int'($urandom_range(0, 9));
         if (mode == 0) begin
            step(1'b0, 1'b1);
         end else if (mode <= 4) begin
            len = int'($urandom_range(5, 40));
            repeat (len) step(1'b1, 1'b0);
         end else if (mode <= 7) begin
            len = int'($urandom_range(1, 4));
            repeat (len) step(1'b0, 1'b0);
         end else begin
            len = int'($urandom_range(20, 70));
            repeat (len) step(1'b0, 1'b0);
         end
      end

      // repeated RUN losses saturate the counter
      phase_tag = "sat";
      step(1'b0, 1'b1);
      repeat (60) step(1'b1, 1'b0);
      for (int k = 0; k < 300; k++) begin
         repeat (3) step(1'b0, 1'b0);
         repeat (17) step(1'b1, 1'b0);
      end
`ifdef PLL_SUP_LOSS_COUNT_EN
      exp_sat = 255;
`else
      exp_sat = 0;
`endif
      check("sat.loss_count", 32'(loss_count), 32'(exp_sat));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for locked_in (minimum 2).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1024, giving the consecutive synchronized-lock cycles required before hold (minimum 2).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 256, giving the core reset extension after stable lock (minimum 1).
REQ-004 The block SHALL have parameter LOCK_TIMEOUT, default 65536, giving the maximum WAIT_LOCK cycles before a PLL reset retry (minimum 2).
REQ-005 The block SHALL have parameter PLL_RST_CYCLES, default 16, giving the pll_rst pulse length (minimum 1).
REQ-006 The block SHALL have port clk, input, 1, the single clock, a free-running reference-domain clock.
REQ-007 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-008 The block SHALL have port locked_in, input, 1, the asynchronous PLL locked indication.
REQ-009 The block SHALL have port pll_rst, output, 1, the active-high PLL reset request.
REQ-010 The block SHALL have port core_reset, output, 1, the active-high reset for the clocked core logic.
REQ-011 The block SHALL have port ready, output, 1, asserted only while the clocks are qualified.
REQ-012 The block SHALL have port lost_pulse, output, 1, a one-cycle strobe on each loss of lock from RUN.
REQ-013 The block SHALL have port loss_count, output, 8, the count of lock-loss events.

Function
REQ-014 locked_in SHALL pass through SYNC_STAGES flops; only the last stage (locked_s) SHALL be used.
REQ-015 The FSM SHALL have states PLL_RST, WAIT_LOCK, STABLE, HOLD and RUN, with a single shared cycle counter cleared on every state entry.
REQ-016 PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK.
REQ-017 WAIT_LOCK: locked_s=1 SHALL go to STABLE; otherwise, at counter=LOCK_TIMEOUT-1, the FSM SHALL go to PLL_RST.
REQ-018 STABLE: locked_s=0 SHALL go to WAIT_LOCK; locked_s=1 at counter=STABLE_CYCLES-1 SHALL go to HOLD, so STABLE lasts STABLE_CYCLES cycles.
REQ-019 HOLD: locked_s=0 SHALL go to WAIT_LOCK; after HOLD_CYCLES cycles the FSM SHALL go to RUN.
REQ-020 RUN: locked_s=0 SHALL go to WAIT_LOCK with lost_pulse=1 for exactly that one cycle.
REQ-021 All outputs SHALL be registered and decoded from next state, so they change in the same cycle as the state.
REQ-022 core_reset SHALL be 1 in every state except RUN; ready SHALL be 1 only in RUN; pll_rst SHALL be 1 only in PLL_RST.
REQ-023 Latency: ready SHALL rise exactly SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES clk edges after the first edge sampling locked_in=1, provided lock is held throughout.
REQ-024 Lock loss in STABLE or HOLD SHALL NOT pulse lost_pulse or change loss_count.
REQ-025 A locked_in glitch shorter than one clk period SHALL be tolerated without metastability propagation; any glitch visible at locked_s SHALL restart qualification.

Reset
REQ-026 While reset=1: state=PLL_RST, counter=0, synchronizer flops=0, pll_rst=1, core_reset=1, ready=0, lost_pulse=0, loss_count=0.
REQ-027 Reset asserted mid-operation, including in RUN, SHALL take effect at the next edge and SHALL NOT pulse lost_pulse.
REQ-028 After reset release, the PLL_RST pulse SHALL last PLL_RST_CYCLES cycles counted from the first non-reset edge.

Configuration
REQ-029 With macro PLL_SUP_LOSS_COUNT_EN defined, loss_count SHALL increment by 1 on every lost_pulse, saturating at 255 and clearing only on reset.
REQ-030 Without PLL_SUP_LOSS_COUNT_EN, loss_count SHALL be constant 0 and no counter registers SHALL be synthesized; the port SHALL remain.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOCK_TIMEOUT=32, PLL_RST_CYCLES=16)
REQ-031 Reset release, then locked_in=1 from cycle 20 -> pll_rst high cycles 0-15; ready and core_reset=0 exactly 15 edges after first sampling of locked_in=1.
REQ-032 locked_in held 0 -> pll_rst pulses 16 cycles, low for 32 cycles, repeating; ready stays 0.
REQ-033 In STABLE, locked_in low for 3 cycles at count 5 -> return to WAIT_LOCK; full 8+4 qualification restarts; lost_pulse stays 0.
REQ-034 In RUN, drop locked_in -> 3 edges later core_reset=1, ready=0, lost_pulse one cycle, loss_count 0->1 (macro on) or stays 0 (macro off).
REQ-035 Repeat the RUN lock-loss 300 times with the macro on -> loss_count saturates at 255.
REQ-036 Assert reset in RUN -> next edge shows all reset values from REQ-026 and lost_pulse=0.
